// File: rtl/maxnet_pkg.sv
// Shared sizing, state encoding and fixed weight constants for the Maxnet parameter loader.
package maxnet_pkg;
    localparam int N       = 4;
    localparam int WORD_W  = 32;
    localparam int N_W     = N * N;
    localparam int N_BEATS = N + N_W;
    localparam int CNT_W   = $clog2(N_BEATS);

    localparam logic [31:0] EPS = 32'hBE000000;
    localparam logic [31:0] ONE = 32'h3F800000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_X = 2'd1,
        LOAD_W = 2'd2,
        DONE   = 2'd3
    } loader_state_t;
endpackage

// File: rtl/maxnet_param_regfile.sv
// Word array with a single write port (enable + address) and a flattened parallel read port.
module maxnet_param_regfile #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4,
    parameter int AW     = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [AW-1:0]             waddr,
    input  logic [WORD_W-1:0]         wdata,
    output logic [DEPTH*WORD_W-1:0]   rdata_flat
);
    logic [DEPTH-1:0][WORD_W-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else if (we) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (waddr == AW'(k)) mem_q[k] <= wdata;
            end
        end
    end

    assign rdata_flat = mem_q;
endmodule

// File: rtl/maxnet_param_loader.sv
// Streams N activations and an NxN weight matrix into registers and presents them in parallel.
// Define MAXNET_WEIGHT_GEN_EN to generate the weights internally (ONE on the diagonal, EPS elsewhere).
module maxnet_param_loader #(
    parameter int          WORD_W = maxnet_pkg::WORD_W,
    parameter int          N      = maxnet_pkg::N,
    parameter logic [31:0] EPS    = maxnet_pkg::EPS,
    parameter logic [31:0] ONE    = maxnet_pkg::ONE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WORD_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N*WORD_W-1:0]     x_flat,
    output logic [N*N*WORD_W-1:0]   w_flat,
    output logic                    params_valid,
    output logic                    busy
);
    import maxnet_pkg::*;

    localparam int NW = N * N;
    localparam int NB = N + NW;
    localparam int CW = $clog2(NB);

    loader_state_t state_q;
    logic [CW-1:0] cnt_q;
    logic          in_ready_q, busy_q, pvalid_q;
    logic          accept, x_we;

    assign accept       = in_valid && in_ready_q;
    assign x_we         = accept && (state_q == LOAD_X);
    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign params_valid = pvalid_q;

    // Outputs are registered alongside the state so they always match it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            pvalid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= LOAD_X;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        pvalid_q   <= 1'b0;
                    end
                end
                LOAD_X: begin
                    if (accept) begin
                        if (cnt_q == CW'(N - 1)) begin
`ifdef MAXNET_WEIGHT_GEN_EN
                            state_q    <= DONE;
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            pvalid_q   <= 1'b1;
`else
                            state_q    <= LOAD_W;
                            cnt_q      <= cnt_q + 1'b1;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                LOAD_W: begin
                    if (accept) begin
                        if (cnt_q == CW'(NB - 1)) begin
                            state_q    <= DONE;
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            pvalid_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    maxnet_param_regfile #(.WORD_W(WORD_W), .DEPTH(N), .AW(CW)) u_xregs (
        .clk        (clk),
        .rst        (rst),
        .we         (x_we),
        .waddr      (cnt_q),
        .wdata      (in_data),
        .rdata_flat (x_flat)
    );

`ifdef MAXNET_WEIGHT_GEN_EN
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            assign w_flat[(i*N+j)*WORD_W +: WORD_W] = (i == j) ? WORD_W'(ONE) : WORD_W'(EPS);
        end
    end
`else
    logic          w_we;
    logic [CW-1:0] w_addr;

    // Weight beats follow the N activations, so rebase the counter to 0.
    assign w_we   = accept && (state_q == LOAD_W);
    assign w_addr = cnt_q - CW'(N);

    maxnet_param_regfile #(.WORD_W(WORD_W), .DEPTH(NW), .AW(CW)) u_wregs (
        .clk        (clk),
        .rst        (rst),
        .we         (w_we),
        .waddr      (w_addr),
        .wdata      (in_data),
        .rdata_flat (w_flat)
    );
`endif
endmodule

// File: tb/tb_maxnet_param_loader.sv
// Scoreboard bench for maxnet_param_loader; the beat count follows MAXNET_WEIGHT_GEN_EN.
module tb_maxnet_param_loader;
    localparam int WW = 32;
    localparam int N  = 4;
    localparam int NW = N * N;
`ifdef MAXNET_WEIGHT_GEN_EN
    localparam int BEATS = N;
`else
    localparam int BEATS = N + NW;
`endif

    logic clk = 1'b0;
    logic rst, start, in_valid, in_ready, params_valid, busy;
    logic [WW-1:0]    in_data;
    logic [N*WW-1:0]  x_flat;
    logic [NW*WW-1:0] w_flat;

    always #5 clk = ~clk;

    maxnet_param_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .x_flat       (x_flat),
        .w_flat       (w_flat),
        .params_valid (params_valid),
        .busy         (busy)
    );

    int          nvec = 0;
    int          nmis = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_exp[BEATS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [31:0] word_at(input int b);
        if (b < N) return x_flat[b*WW +: WW];
        return w_flat[(b-N)*WW +: WW];
    endfunction

    // Drive nb beats starting at base+1; a start pulse rides along on beat start_at.
    task automatic send(input logic [31:0] base, input bit toggle, input int start_at, input int nb);
        for (int b = 0; b < nb; b++) begin
            if (toggle) begin
                in_valid = 1'b0;
                in_data  = 32'hDEADBEEF;
                tick();
            end
            in_valid = 1'b1;
            in_data  = base + 32'(b) + 32'd1;
            start    = (b == start_at);
            chk("rdy_load", {31'd0, in_ready}, 32'd1);
            chk("pv_load", {31'd0, params_valid}, 32'd0);
            sb_q.push_back(in_data);
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_done();
        logic [31:0] e;
        chk("pv_done", {31'd0, params_valid}, 32'd1);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("rdy_done", {31'd0, in_ready}, 32'd0);
        for (int b = 0; b < BEATS; b++) begin
            e = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hXXXXXXXX;
            last_exp[b] = e;
            chk($sformatf("word%0d", b), word_at(b), e);
        end
`ifdef MAXNET_WEIGHT_GEN_EN
        for (int k = 0; k < NW; k++)
            chk($sformatf("wgen%0d", k), w_flat[k*WW +: WW],
                ((k / N) == (k % N)) ? 32'h3F800000 : 32'hBE000000);
`endif
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_pv"}, {31'd0, params_valid}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        for (int b = 0; b < N; b++) chk($sformatf("%s_x%0d", tag, b), x_flat[b*WW +: WW], 32'd0);
`ifndef MAXNET_WEIGHT_GEN_EN
        for (int k = 0; k < NW; k++) chk($sformatf("%s_w%0d", tag, k), w_flat[k*WW +: WW], 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        tick(); tick();
        rst = 1'b0;
        check_cleared("reset");

        // Stray valid data in IDLE must be ignored.
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        tick(); tick(); tick();
        in_valid = 1'b0;
        check_cleared("idle_junk");

        // Back-to-back stream; params_valid must appear right after the last accept edge.
        pulse_start();
        chk("busy_start", {31'd0, busy}, 32'd1);
        send(32'd0, 1'b0, -1, BEATS);
        check_done();

        // Stray valid data in DONE must be ignored.
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk("done_junk_rdy", {31'd0, in_ready}, 32'd0);
        chk("done_junk_pv", {31'd0, params_valid}, 32'd1);
        for (int b = 0; b < BEATS; b++) chk($sformatf("done_junk%0d", b), word_at(b), last_exp[b]);

        // Reload with stalls; params_valid must drop right after start.
        pulse_start();
        chk("pv_fall", {31'd0, params_valid}, 32'd0);
        chk("old_kept", word_at(0), last_exp[0]);
        send(32'h100, 1'b1, -1, BEATS);
        check_done();

        // start mid-sequence is ignored.
        pulse_start();
        send(32'h200, 1'b0, BEATS - 2, BEATS);
        check_done();

        // Reset part-way through a load clears everything.
        pulse_start();
        send(32'h300, 1'b0, -1, BEATS / 2);
        sb_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cleared("mid_rst");

        // rst beats start when both arrive together.
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        chk("rst_start_rdy", {31'd0, in_ready}, 32'd0);

        pulse_start();
`ifdef MAXNET_WEIGHT_GEN_EN
        send(32'h3F7FFFFF, 1'b0, -1, BEATS);
`else
        send(32'h400, 1'b0, -1, BEATS);
`endif
        check_done();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
